// File: rtl/digits_to_number.sv
// digits_to_number
//   Converts three BCD digits (hundreds, tens, ones) into an unsigned binary
//   value. It does one multiply-by-ten-and-add step per clock. The result is
//   clamped to MAX_VALUE and held until the next conversion. A one-cycle done
//   pulse marks each update.
//
//   Optional feature macro: DIGIT_CHECK_EN
//     defined     : a latched digit > 9 gives err=1, number=0, ovf=0
//     not defined : err is always 0; digits 10..15 are weighted arithmetically
//
//   Ports
//     clk      in   system clock, rising edge
//     rst      in   synchronous, active-high reset
//     start    in   latch digits and begin conversion (only honoured in IDLE)
//     digit_1  in   ones digit
//     digit_2  in   tens digit
//     digit_3  in   hundreds digit
//     busy     out  conversion in progress
//     done     out  one-cycle pulse: number/ovf/err just updated
//     number   out  converted value (OUT_W bits), held between conversions
//     ovf      out  last result exceeded MAX_VALUE and was clamped
//     err      out  last conversion saw a non-BCD digit
module digits_to_number #(
   parameter int unsigned OUT_W     = 11,
   parameter int unsigned MAX_VALUE = 999
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       digit_1,
   input  logic [3:0]       digit_2,
   input  logic [3:0]       digit_3,
   output logic             busy,
   output logic             done,
   output logic [OUT_W-1:0] number,
   output logic             ovf,
   output logic             err
);

   typedef enum logic [1:0] {S_IDLE, S_STEP, S_FINISH} state_e;

   state_e           state_q;
   logic [1:0]       k_q;
   logic [11:0]      acc_q;
   logic [3:0]       d1_q, d2_q, d3_q;
   logic             busy_q, done_q, ovf_q, err_q;
   logic [OUT_W-1:0] number_q;

   logic [11:0]      acc_d;
   logic [OUT_W-1:0] number_d;
   logic             ovf_d, err_d;
   logic             over;

   // The 12-bit accumulator holds the worst case 15*111 = 1665, so x10 never wraps.
   always_comb begin
      acc_d = 12'd0;
      unique case (k_q)
         2'd2:    acc_d = {8'd0, d3_q};
         2'd1:    acc_d = (acc_q << 3) + (acc_q << 1) + {8'd0, d2_q};
         default: acc_d = (acc_q << 3) + (acc_q << 1) + {8'd0, d1_q};
      endcase
   end

   always_comb begin
      over     = ({20'd0, acc_q} > MAX_VALUE);
      number_d = OUT_W'(over ? MAX_VALUE : {20'd0, acc_q});
      ovf_d    = over;
      err_d    = 1'b0;
`ifdef DIGIT_CHECK_EN
      if (d1_q > 4'd9 || d2_q > 4'd9 || d3_q > 4'd9) begin
         err_d    = 1'b1;
         number_d = '0;
         ovf_d    = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         k_q      <= 2'd0;
         acc_q    <= 12'd0;
         d1_q     <= 4'd0;
         d2_q     <= 4'd0;
         d3_q     <= 4'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         number_q <= '0;
         ovf_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  d1_q    <= digit_1;
                  d2_q    <= digit_2;
                  d3_q    <= digit_3;
                  acc_q   <= 12'd0;
                  k_q     <= 2'd2;
                  busy_q  <= 1'b1;
                  state_q <= S_STEP;
               end
            end
            S_STEP: begin
               acc_q <= acc_d;
               if (k_q == 2'd0) state_q <= S_FINISH;
               else             k_q     <= k_q - 2'd1;
            end
            S_FINISH: begin
               number_q <= number_d;
               ovf_q    <= ovf_d;
               err_q    <= err_d;
               done_q   <= 1'b1;
               busy_q   <= 1'b0;
               state_q  <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign number = number_q;
   assign ovf    = ovf_q;
   assign err    = err_q;

endmodule
